// File: rtl/video_timing_meas.sv
// Video timing measurement: re-registers the receiver's sync and pixel stream, tags
// each active pixel with its column/row, and measures frame size to report lock.
module video_timing_meas #(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter bit          VS_ACT_HIGH = 1'b1
) (
    input  logic        odck_in,
    input  logic        rst,
    input  logic        scdt_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        de_in,
    input  logic [7:0]  pixel_r_in,
    input  logic [7:0]  pixel_g_in,
    input  logic [7:0]  pixel_b_in,
    output logic        vsync_o,
    output logic        hsync_o,
    output logic        de_o,
    output logic [7:0]  pixel_r_o,
    output logic [7:0]  pixel_g_o,
    output logic [7:0]  pixel_b_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        sof_o,
    output logic [11:0] h_active_o,
    output logic [11:0] v_active_o,
    output logic        locked_o,
    output logic        frame_done_o
);

    localparam logic [3:0]  LOCK_CNT = 4'(LOCK_FRAMES);
    localparam logic [11:0] CNT_MAX  = '1;

    logic        de_d;
    logic        vs_d;
    logic [11:0] x_cnt;
    logic [11:0] y_cnt;
    logic [11:0] line_w;
    logic        bad;
    logic        armed;
    logic [3:0]  match;

    logic        vs_act;
    logic        line_end;
    logic        frame_edge;
    logic [11:0] x_inc;
    logic [11:0] y_inc;
    logic        width_err;
    logic [11:0] y_close;
    logic [11:0] lw_close;
    logic        bad_close;
    logic        good;
    logic        same_dims;
    logic [3:0]  match_next;

    // Values seen by the closing frame include a line end on the same sample.
    always_comb begin
        vs_act     = VS_ACT_HIGH ? vsync_in : ~vsync_in;
        line_end   = de_d & ~de_in;
        frame_edge = ~vs_d & vs_act;
        x_inc      = (x_cnt == CNT_MAX) ? x_cnt : x_cnt + 12'd1;
        y_inc      = (y_cnt == CNT_MAX) ? y_cnt : y_cnt + 12'd1;
        width_err  = line_end && (y_cnt != '0) && (x_cnt != line_w);
        y_close    = line_end ? y_inc : y_cnt;
        lw_close   = (line_end && (y_cnt == '0)) ? x_cnt : line_w;
        bad_close  = bad | width_err;
        good       = armed && !bad_close && (y_close != '0) && (lw_close != '0);
        same_dims  = (match != '0) && (lw_close == h_active_o) && (y_close == v_active_o);
        match_next = '0;
        if (good) begin
            if (!same_dims)
                match_next = 4'd1;
            else if (match >= LOCK_CNT)
                match_next = LOCK_CNT;
            else
                match_next = match + 4'd1;
        end
    end

    always_ff @(posedge odck_in or negedge rst) begin
        if (!rst) begin
            vsync_o   <= 1'b0;
            hsync_o   <= 1'b0;
            pixel_r_o <= '0;
            pixel_g_o <= '0;
            pixel_b_o <= '0;
        end else begin
            vsync_o   <= vsync_in;
            hsync_o   <= hsync_in;
            pixel_r_o <= pixel_r_in;
            pixel_g_o <= pixel_g_in;
            pixel_b_o <= pixel_b_in;
        end
    end

    always_ff @(posedge odck_in or negedge rst) begin
        if (!rst) begin
            de_d         <= 1'b0;
            vs_d         <= 1'b0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            line_w       <= '0;
            bad          <= 1'b0;
            armed        <= 1'b0;
            match        <= '0;
            de_o         <= 1'b0;
            sof_o        <= 1'b0;
            frame_done_o <= 1'b0;
            x_o          <= '0;
            y_o          <= '0;
            h_active_o   <= '0;
            v_active_o   <= '0;
            locked_o     <= 1'b0;
        end else begin
            de_d <= de_in;
            vs_d <= vs_act;
            if (!scdt_in) begin
                de_o         <= 1'b0;
                sof_o        <= 1'b0;
                frame_done_o <= 1'b0;
                x_cnt        <= '0;
                y_cnt        <= '0;
                bad          <= 1'b0;
                armed        <= 1'b0;
                match        <= '0;
                locked_o     <= 1'b0;
            end else begin
                de_o         <= de_in;
                sof_o        <= de_in && (x_cnt == '0) && (y_cnt == '0);
                frame_done_o <= frame_edge;
                if (de_in) begin
                    x_o   <= x_cnt;
                    y_o   <= y_cnt;
                    x_cnt <= x_inc;
                end
                if (line_end) begin
                    x_cnt <= '0;
                    y_cnt <= y_inc;
                    if (y_cnt == '0)
                        line_w <= x_cnt;
                    else if (x_cnt != line_w)
                        bad <= 1'b1;
                end
                // Later assignments win: a boundary overrides the line-end counter updates.
                if (frame_edge) begin
                    x_cnt    <= '0;
                    y_cnt    <= '0;
                    bad      <= 1'b0;
                    armed    <= 1'b1;
                    match    <= match_next;
                    locked_o <= (match_next == LOCK_CNT);
                    if (good) begin
                        h_active_o <= lw_close;
                        v_active_o <= y_close;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_meas.sv
// Directed bench for video_timing_meas: frames of known size with hand-computed
// positions, measured dimensions and lock behaviour.
module tb_video_timing_meas;

    logic        odck;
    logic        rst;
    logic        scdt;
    logic        vsync;
    logic        hsync;
    logic        de;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        vsync_o;
    logic        hsync_o;
    logic        de_o;
    logic [7:0]  pix_r_o;
    logic [7:0]  pix_g_o;
    logic [7:0]  pix_b_o;
    logic [11:0] x_o;
    logic [11:0] y_o;
    logic        sof_o;
    logic [11:0] h_act;
    logic [11:0] v_act;
    logic        locked;
    logic        frame_done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    video_timing_meas #(
        .LOCK_FRAMES (2),
        .VS_ACT_HIGH (1'b1)
    ) dut (
        .odck_in      (odck),
        .rst          (rst),
        .scdt_in      (scdt),
        .vsync_in     (vsync),
        .hsync_in     (hsync),
        .de_in        (de),
        .pixel_r_in   (pix_r),
        .pixel_g_in   (pix_g),
        .pixel_b_in   (pix_b),
        .vsync_o      (vsync_o),
        .hsync_o      (hsync_o),
        .de_o         (de_o),
        .pixel_r_o    (pix_r_o),
        .pixel_g_o    (pix_g_o),
        .pixel_b_o    (pix_b_o),
        .x_o          (x_o),
        .y_o          (y_o),
        .sof_o        (sof_o),
        .h_active_o   (h_act),
        .v_active_o   (v_act),
        .locked_o     (locked),
        .frame_done_o (frame_done)
    );

    initial odck = 1'b0;
    always #5 odck = ~odck;

    initial begin
        #2000000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge odck);
        #1;
    endtask

    task automatic expect_quiet(input string tag);
        check({tag, "_vsync"}, 32'(vsync_o), 0);
        check({tag, "_hsync"}, 32'(hsync_o), 0);
        check({tag, "_de"}, 32'(de_o), 0);
        check({tag, "_r"}, 32'(pix_r_o), 0);
        check({tag, "_g"}, 32'(pix_g_o), 0);
        check({tag, "_b"}, 32'(pix_b_o), 0);
        check({tag, "_x"}, 32'(x_o), 0);
        check({tag, "_y"}, 32'(y_o), 0);
        check({tag, "_sof"}, 32'(sof_o), 0);
        check({tag, "_h"}, 32'(h_act), 0);
        check({tag, "_v"}, 32'(v_act), 0);
        check({tag, "_lock"}, 32'(locked), 0);
        check({tag, "_fdone"}, 32'(frame_done), 0);
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        step();
        check("fdone_hi", 32'(frame_done), 1);
        vsync = 1'b0;
        step();
        check("fdone_lo", 32'(frame_done), 0);
    endtask

    task automatic line(input int w, input int row);
        for (int i = 0; i < w; i++) begin
            de    = 1'b1;
            pix_g = 8'(i);
            step();
            check("x", 32'(x_o), 32'(i));
            check("y", 32'(y_o), 32'(row));
            check("de_on", 32'(de_o), 1);
            check("sof", 32'(sof_o), (row == 0 && i == 0) ? 1 : 0);
            check("pix_g", 32'(pix_g_o), 32'(i[7:0]));
        end
        de = 1'b0;
        step();
        check("de_off", 32'(de_o), 0);
        step();
    endtask

    task automatic frame(input int w, input int h, input int alt_row, input int alt_w);
        for (int r = 0; r < h; r++)
            line((r == alt_row) ? alt_w : w, r);
        vs_pulse();
    endtask

    task automatic expect_meas(input string tag, input int h, input int v, input int lk);
        check({tag, "_h"}, 32'(h_act), 32'(h));
        check({tag, "_v"}, 32'(v_act), 32'(v));
        check({tag, "_lock"}, 32'(locked), 32'(lk));
    endtask

    initial begin
        rst = 1'b0; scdt = 1'b0; vsync = 1'b0; hsync = 1'b0; de = 1'b0;
        pix_r = '0; pix_g = '0; pix_b = '0;

        // reset with garbage on every input
        for (int i = 0; i < 6; i++) begin
            scdt  = 1'($urandom);
            vsync = 1'($urandom);
            hsync = 1'($urandom);
            de    = 1'($urandom);
            pix_r = 8'($urandom);
            pix_g = 8'($urandom);
            pix_b = 8'($urandom);
            step();
        end
        expect_quiet("rst");
        scdt = 1'b1; vsync = 1'b0; hsync = 1'b0; de = 1'b0;
        pix_r = '0; pix_g = '0; pix_b = '0;
        rst = 1'b1;
        repeat (3) step();
        expect_quiet("post_rst");

        // basic 4x3 frames: measure after 2nd vsync, lock after 3rd
        vs_pulse();
        frame(4, 3, 99, 0);
        expect_meas("basic1", 4, 3, 0);
        frame(4, 3, 99, 0);
        expect_meas("basic2", 4, 3, 1);

        // width error on line 1 drops lock and holds dimensions
        frame(4, 3, 1, 5);
        expect_meas("werr", 4, 3, 0);
        frame(4, 3, 99, 0);
        expect_meas("werr_c1", 4, 3, 0);
        frame(4, 3, 99, 0);
        expect_meas("werr_c2", 4, 3, 1);

        // resolution change to 6x2
        frame(6, 2, 99, 0);
        expect_meas("res1", 6, 2, 0);
        frame(6, 2, 99, 0);
        expect_meas("res2", 6, 2, 1);

        // signal loss mid-frame
        line(6, 0);
        scdt  = 1'b0;
        de    = 1'b1;
        pix_r = 8'h5A;
        step();
        check("scdt_de", 32'(de_o), 0);
        check("scdt_sof", 32'(sof_o), 0);
        check("scdt_pix", 32'(pix_r_o), 32'h5A);
        expect_meas("scdt_drop", 6, 2, 0);
        de = 1'b0;
        pix_r = '0;
        repeat (99) step();
        scdt = 1'b1;
        step();
        line(5, 0);
        vs_pulse();
        expect_meas("scdt_arm", 6, 2, 0);
        frame(6, 2, 99, 0);
        expect_meas("scdt_r1", 6, 2, 0);
        frame(6, 2, 99, 0);
        expect_meas("scdt_r2", 6, 2, 1);

        // 5000-pixel line saturates the column counter
        for (int i = 0; i < 5000; i++) begin
            de = 1'b1;
            step();
            if (i == 4094) check("sat_4094", 32'(x_o), 4094);
            if (i == 4095) check("sat_4095", 32'(x_o), 4095);
            if (i == 4999) check("sat_last", 32'(x_o), 4095);
        end
        de = 1'b0;
        step();
        step();
        vs_pulse();
        expect_meas("sat_meas", 4095, 1, 0);

        // last line's de falls on the same sample as the vsync edge
        line(4, 0);
        line(4, 1);
        for (int i = 0; i < 4; i++) begin
            de = 1'b1;
            step();
            check("coin_x", 32'(x_o), 32'(i));
            check("coin_y", 32'(y_o), 2);
        end
        de    = 1'b0;
        vsync = 1'b1;
        step();
        check("coin_fdone", 32'(frame_done), 1);
        expect_meas("coin", 4, 3, 0);
        vsync = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_meas.md
VIDEO_TIMING_MEAS -- requirements
Module: video_timing_meas

Interface
REQ-001 Param LOCK_FRAMES, default 2, meaning consecutive identical good frames needed to assert locked_o (range 1..15).
REQ-002 Param VS_ACT_HIGH, default 1, meaning vsync_in active level (1 = high, 0 = low).
REQ-003 odck_in  in  1  pixel clock, all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 scdt_in  in  1  upstream signal-valid indicator.
REQ-006 vsync_in, hsync_in, de_in  in  1 each  raw sync and data-enable from the receiver.
REQ-007 pixel_r_in, pixel_g_in, pixel_b_in  in  8 each  pixel colour.
REQ-008 vsync_o, hsync_o, de_o  out  1 each  registered copies of the sync inputs; de_o gated by scdt_in.
REQ-009 pixel_r_o, pixel_g_o, pixel_b_o  out  8 each  registered pixel colour.
REQ-010 x_o, y_o  out  12 each  column and row of the pixel presented with de_o=1.
REQ-011 sof_o  out  1  start-of-frame pulse, high with pixel (0,0).
REQ-012 h_active_o, v_active_o  out  12 each  last measured good active width and height.
REQ-013 locked_o  out  1  timing stable.
REQ-014 frame_done_o  out  1  one-cycle pulse at each frame boundary.

Function
REQ-015 Fixed latency: all *_o video, x_o, y_o and sof_o change exactly 1 odck_in cycle after the corresponding input sample.
REQ-016 Internal state: de_d and vs_d hold the previous de_in and the previous active-level vsync_in.
REQ-017 Counters: x_cnt and y_cnt are 12-bit; line_w holds the first line width of the current frame; bad holds the frame-error flag.
REQ-018 On each sample with de_in=1 and scdt_in=1: x_o<=x_cnt, y_o<=y_cnt, de_o<=1, and x_cnt increments, saturating at 4095.
REQ-019 sof_o<=1 on a sample where de_in=1, x_cnt=0 and y_cnt=0; otherwise 0.
REQ-020 Line end is de_d=1 with de_in=0; on line end, x_cnt<=0 and y_cnt increments, saturating at 4095.
REQ-021 On the first line end of a frame (y_cnt=0), line_w<=x_cnt; on later line ends, x_cnt!=line_w sets bad.
REQ-022 Frame boundary is vs_d=0 with vsync active in the current sample; on a frame boundary, frame_done_o<=1 for one cycle, and x_cnt, y_cnt and bad clear.
REQ-023 A frame is good when bad=0, y_cnt!=0 and line_w!=0 at the boundary.
REQ-024 A frame boundary coincident with a line end: the line end is applied first, so its width check and row count are included in the closing frame.
REQ-025 Good frame: h_active_o<=line_w and v_active_o<=y_cnt.
REQ-026 Bad frame: h_active_o and v_active_o hold their previous values.
REQ-027 A 4-bit match counter counts consecutive good frames whose (line_w, y_cnt) equals the previous good frame, saturating at LOCK_FRAMES.
REQ-028 The first good frame after a clear loads match=1.
REQ-029 locked_o=1 iff match counter = LOCK_FRAMES.
REQ-030 A bad frame, or a good frame with different dimensions, sets match to 0 (or 1 for the different good frame) and clears locked_o at that boundary.
REQ-031 While scdt_in=0, the following clear or are forced to 0: de_o, sof_o, frame_done_o, x_cnt, y_cnt, bad, match, locked_o.
REQ-032 While scdt_in=0, h_active_o and v_active_o hold their values; sync and pixel outputs still pass with 1-cycle latency.
REQ-033 On scdt_in rising, the first frame boundary starts measurement; data before that boundary is counted but never reported as good.

Reset
REQ-034 While rst=0, every output, counter and flag is 0; this includes h_active_o, v_active_o, locked_o and pixel outputs.
REQ-035 First edge after rst releases: de_d=0 and vs_d=0, so a vsync already active at release counts as a boundary.
REQ-036 Reset asserted mid-frame: state is discarded and measurement restarts at the next boundary.

Verification
REQ-037 Reset: assert rst=0 with random inputs -> all outputs 0; release -> outputs stay 0 until stimulus arrives.
REQ-038 Basic frame: LOCK_FRAMES=2, 4 px x 3 lines between vsyncs -> x_o sweeps 0..3, y_o sweeps 0..2, sof_o high once at (0,0) 1 cycle after first de_in, h_active_o=4 and v_active_o=3 after 2nd vsync, locked_o=1 after 3rd vsync.
REQ-039 Width error: a locked 4x3 stream with line 2 of 5 px -> at the boundary, locked_o=0 and h/v outputs hold 4/3; two more clean frames -> locked_o=1.
REQ-040 Resolution change: a locked 4x3 stream, then 6x2 frames -> locked_o falls at the first 6x2 boundary, h/v become 6/2, relock after 2 frames.
REQ-041 scdt drop: scdt_in=0 for 100 cycles mid-frame -> de_o=0 and locked_o=0 at once, h/v retained; relock needs boundary plus LOCK_FRAMES good frames.
REQ-042 Saturation and coincidence: 5000-px line -> x_o stops at 4095; de falling on the same cycle as vsync edge -> last line counted in v_active_o.
